dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Sits in front of the data memory (DM) and shares its single port between two requesters.
//  - Requester 1: pipeline MEM stage (CPU).
//  - Requester 2: word-wide loader/debug port (LD).
//  Decodes CPU load/store size and sign into DM byte enables and sign control, and flags misaligned CPU accesses.
//  CPU has priority; a starvation counter guarantees LD forward progress by stalling the CPU.
// PARAMETERS
//  STARVE_LIMIT  8   consecutive LD waiting cycles before a forced LD grant (1..255)
//  CNT_W         32  width of the performance counters
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  cpu_req_i     in   1   CPU access valid this cycle
//  cpu_we_i      in   1   1=store, 0=load
//  cpu_op_i      in   3   000 b, 001 h, 010 w, 100 bu, 101 hu; other codes = no access
//  cpu_addr_i    in   32  byte address
//  cpu_wdata_i   in   32  store data, right-aligned (sb uses [7:0], sh uses [15:0])
//  cpu_rdata_o   out  32  load data (combinational from DM)
//  cpu_stall_o   out  1   CPU access not performed this cycle; hold MEM stage
//  cpu_ade_o     out  1   misaligned CPU access; no DM access
//  ld_req_i      in   1   LD request; held until ld_gnt_o
//  ld_we_i       in   1   LD write
//  ld_addr_i     in   32  LD byte address; [1:0] ignored (word access)
//  ld_wdata_i    in   32  LD write word
//  ld_gnt_o      out  1   LD access performed this cycle
//  ld_rvalid_o   out  1   ld_rdata_o valid (1 cycle after a read grant)
//  ld_rdata_o    out  32  registered LD read word
//  dm_addr_o     out  32  DM address
//  dm_wdata_o    out  32  DM write data
//  dm_we_o       out  1   DM write enable
//  dm_be_o       out  4   DM byte enables
//  dm_sign_o     out  1   DM sign-extend select
//  dm_rdata_i    in   32  DM read data (combinational)
//  perf_cpu_o    out  CNT_W  count of performed CPU accesses
//  perf_stall_o  out  CNT_W  count of cycles with cpu_stall_o=1
// BEHAVIOUR
//  Reset: ld_rvalid_o=0, ld_rdata_o=0, starvation count=0, perf counters=0.
//  Decode (combinational):
//   - b/bu: be = 4'b0001 << addr[1:0].
//   - h/hu: be = addr[1] ? 4'b1100 : 4'b0011.
//   - w:    be = 4'b1111.
//   - sign = ~cpu_op_i[2].
//  Misalignment: cpu_ade_o = cpu_req_i & ((half & addr[0]) | (word & |addr[1:0])).
//   A misaligned or invalid-op CPU request is treated as "no CPU request" for arbitration.
//  Arbitration per cycle (combinational grant, cnt = starvation count):
//   - force = ld_req_i & (cnt == STARVE_LIMIT).
//   - LD granted if ld_req_i & (force | no valid CPU request).
//   - CPU performed if valid CPU request & ~force.
//   - cpu_stall_o = valid CPU request & force.
//  DM drive:
//   - CPU granted: addr/wdata/we/be/sign from CPU.
//   - LD granted: {ld_addr_i[31:2],2'b00}, be=1111, sign=0, we=ld_we_i.
//   - Neither: we=0, be=0000, addr=0, wdata=0.
//  Counter:
//   - cnt+1 when ld_req_i & ~ld_gnt_o.
//   - cnt cleared on ld_gnt_o or ~ld_req_i.
//   - Never exceeds STARVE_LIMIT.
//  LD read: on granted read, ld_rdata_o <= dm_rdata_i and ld_rvalid_o <= 1 at next edge; rvalid is a 1-cycle pulse.
//  Back-to-back: after a forced grant cnt=0, so the CPU is never stalled two cycles in a row.
//  Reset mid-operation: pending rvalid dropped; LD must re-request.
// CONFIGURATION
//  DM_ARB_PERF_EN defined:
//   - perf_cpu_o increments on each performed CPU access.
//   - perf_stall_o increments on each stall cycle.
//   - Both wrap at 2^CNT_W.
//  DM_ARB_PERF_EN undefined: no counter flops; perf_cpu_o and perf_stall_o tied to 0.
// TESTING
//  1. CPU sh, data 0xBEEF @0x6 -> be=1100, we=1; then CPU lh @0x6 -> cpu_rdata_o=0xFFFFBEEF, lhu -> 0x0000BEEF.
//  2. CPU lw @0x5 -> cpu_ade_o=1, dm_we_o=0, be=0000; concurrent ld_req_i -> ld_gnt_o=1 that cycle.
//  3. LD read @0x10 (holds 0x12345678), CPU idle -> ld_gnt_o same cycle; next cycle ld_rvalid_o=1, ld_rdata_o=0x12345678.
//  4. CPU req every cycle, LD req held, STARVE_LIMIT=8 -> ld_gnt_o and cpu_stall_o on cycle 9; CPU performed on cycle 10.
//  5. LD write 0xA5A5A5A5 @0x23 -> dm_addr_o=0x20, be=1111; rst asserted during rvalid cycle -> ld_rvalid_o=0 immediately.
//  6. With DM_ARB_PERF_EN, rerun scenario 4 -> perf_stall_o=1, perf_cpu_o=9; without the macro both read 0.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Shares the data-memory port between the CPU MEM stage and a word-wide loader port.
// Optional performance counters are enabled by defining DM_ARB_PERF_EN.
module dm_port_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req_i,
    input  logic             cpu_we_i,
    input  logic [2:0]       cpu_op_i,
    input  logic [31:0]      cpu_addr_i,
    input  logic [31:0]      cpu_wdata_i,
    output logic [31:0]      cpu_rdata_o,
    output logic             cpu_stall_o,
    output logic             cpu_ade_o,
    input  logic             ld_req_i,
    input  logic             ld_we_i,
    input  logic [31:0]      ld_addr_i,
    input  logic [31:0]      ld_wdata_i,
    output logic             ld_gnt_o,
    output logic             ld_rvalid_o,
    output logic [31:0]      ld_rdata_o,
    output logic [31:0]      dm_addr_o,
    output logic [31:0]      dm_wdata_o,
    output logic             dm_we_o,
    output logic [3:0]       dm_be_o,
    output logic             dm_sign_o,
    input  logic [31:0]      dm_rdata_i,
    output logic [CNT_W-1:0] perf_cpu_o,
    output logic [CNT_W-1:0] perf_stall_o
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic       is_b;
    logic       is_h;
    logic       is_w;
    logic [3:0] cpu_be;
    logic       cpu_valid;
    logic       force_ld;
    logic       cpu_go;
    logic [7:0] cnt;

    assign is_b = (cpu_op_i == 3'b000) || (cpu_op_i == 3'b100);
    assign is_h = (cpu_op_i == 3'b001) || (cpu_op_i == 3'b101);
    assign is_w = (cpu_op_i == 3'b010);

    always_comb begin
        cpu_be = 4'b0000;
        unique case (1'b1)
            is_b:    cpu_be = 4'b0001 << cpu_addr_i[1:0];
            is_h:    cpu_be = cpu_addr_i[1] ? 4'b1100 : 4'b0011;
            is_w:    cpu_be = 4'b1111;
            default: cpu_be = 4'b0000;
        endcase
    end

    assign cpu_ade_o = cpu_req_i &
                       ((is_h & cpu_addr_i[0]) | (is_w & |cpu_addr_i[1:0]));

    // Misaligned or undefined ops never compete for the port.
    assign cpu_valid   = cpu_req_i & (is_b | is_h | is_w) & ~cpu_ade_o;
    assign force_ld    = ld_req_i & (cnt == LIMIT);
    assign ld_gnt_o    = ld_req_i & (force_ld | ~cpu_valid);
    assign cpu_go      = cpu_valid & ~force_ld;
    assign cpu_stall_o = cpu_valid & force_ld;
    assign cpu_rdata_o = dm_rdata_i;

    always_comb begin
        dm_addr_o  = 32'd0;
        dm_wdata_o = 32'd0;
        dm_we_o    = 1'b0;
        dm_be_o    = 4'b0000;
        dm_sign_o  = 1'b0;
        if (cpu_go) begin
            dm_addr_o  = cpu_addr_i;
            dm_wdata_o = cpu_wdata_i;
            dm_we_o    = cpu_we_i;
            dm_be_o    = cpu_be;
            dm_sign_o  = ~cpu_op_i[2];
        end else if (ld_gnt_o) begin
            dm_addr_o  = {ld_addr_i[31:2], 2'b00};
            dm_wdata_o = ld_wdata_i;
            dm_we_o    = ld_we_i;
            dm_be_o    = 4'b1111;
        end
    end

    // A forced grant clears the count, so the limit is never exceeded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (ld_req_i & ~ld_gnt_o) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_rvalid_o <= 1'b0;
            ld_rdata_o  <= 32'd0;
        end else begin
            ld_rvalid_o <= ld_gnt_o & ~ld_we_i;
            if (ld_gnt_o & ~ld_we_i) begin
                ld_rdata_o <= dm_rdata_i;
            end
        end
    end

`ifdef DM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cpu_o   <= '0;
            perf_stall_o <= '0;
        end else begin
            if (cpu_go) begin
                perf_cpu_o <= perf_cpu_o + 1'b1;
            end
            if (cpu_stall_o) begin
                perf_stall_o <= perf_stall_o + 1'b1;
            end
        end
    end
`else
    assign perf_cpu_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: a reference model queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_dm_port_arbiter;

    localparam int LIMIT = 8;
`ifdef DM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_i = 0, cpu_we_i = 0;
    logic [2:0]  cpu_op_i = 3'b011;
    logic [31:0] cpu_addr_i = 0, cpu_wdata_i = 0;
    logic [31:0] cpu_rdata_o;
    logic        cpu_stall_o, cpu_ade_o;
    logic        ld_req_i = 0, ld_we_i = 0;
    logic [31:0] ld_addr_i = 0, ld_wdata_i = 0;
    logic        ld_gnt_o, ld_rvalid_o;
    logic [31:0] ld_rdata_o;
    logic [31:0] dm_addr_o, dm_wdata_o;
    logic        dm_we_o, dm_sign_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_rdata_i;
    logic [31:0] perf_cpu_o, perf_stall_o;

    always #5 clk = ~clk;

    dm_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_op_i(cpu_op_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
        .cpu_ade_o(cpu_ade_o),
        .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
        .ld_wdata_i(ld_wdata_i), .ld_gnt_o(ld_gnt_o),
        .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
        .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o), .dm_we_o(dm_we_o),
        .dm_be_o(dm_be_o), .dm_sign_o(dm_sign_o), .dm_rdata_i(dm_rdata_i),
        .perf_cpu_o(perf_cpu_o), .perf_stall_o(perf_stall_o)
    );

    // Data memory: lane steering and sign extension live here.
    logic [31:0] dm [16];
    initial for (int i = 0; i < 16; i++) dm[i] = 32'd0;

    always_comb begin
        logic [31:0] w;
        w = dm[dm_addr_o[5:2]] >> (8 * dm_addr_o[1:0]);
        case ($countones(dm_be_o))
            1: dm_rdata_i = dm_sign_o ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
            2: dm_rdata_i = dm_sign_o ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
            default: dm_rdata_i = dm[dm_addr_o[5:2]];
        endcase
    end

    always @(posedge clk) begin
        logic [31:0] sw;
        sw = dm_wdata_o << (8 * dm_addr_o[1:0]);
        if (dm_we_o)
            for (int i = 0; i < 4; i++)
                if (dm_be_o[i]) dm[dm_addr_o[5:2]][8*i +: 8] <= sw[8*i +: 8];
    end

    typedef struct {
        logic ade, stall, gnt, go, we, sign, rv;
        logic [3:0] be;
        logic [31:0] addr, wdata, rdata, ldr;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] rm [16];
    int wait_c = 0;
    logic pend_rv = 0;
    logic [31:0] pend_d = 0;
    int n_cpu = 0, n_stall = 0;
    logic m_gnt;

    initial for (int i = 0; i < 16; i++) rm[i] = 32'd0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endfunction

    task automatic step(input logic cr, input logic cw, input logic [2:0] op,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic lr, input logic lw,
                        input logic [31:0] la, input logic [31:0] ld);
        exp_t e;
        int sz;
        bit opv, mis, cv, frc;
        longint mask, v;
        @(posedge clk);
        #1;
        cpu_req_i = cr; cpu_we_i = cw; cpu_op_i = op;
        cpu_addr_i = ca; cpu_wdata_i = cd;
        ld_req_i = lr; ld_we_i = lw; ld_addr_i = la; ld_wdata_i = ld;

        sz  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        opv = (op == 0) || (op == 1) || (op == 2) || (op == 4) || (op == 5);
        mis = cr && opv && ((ca % sz) != 0);
        cv  = cr && opv && !mis;
        frc = lr && (wait_c == LIMIT);
        e.ade   = mis;
        e.gnt   = lr && (frc || !cv);
        e.go    = cv && !frc;
        e.stall = cv && frc;
        e.we = 0; e.sign = 0; e.be = 0;
        e.addr = 0; e.wdata = 0; e.rdata = 0;
        e.rv = pend_rv; e.ldr = pend_d;
        if (e.go) begin
            e.we = cw; e.addr = ca; e.wdata = cd;
            e.sign = (op < 4);
            e.be = 4'(((1 << sz) - 1) << (ca % 4));
            mask = (sz == 4) ? 64'hFFFF_FFFF : ((64'd1 << (8 * sz)) - 1);
            v = longint'(rm[ca[5:2]] >> (8 * (ca % 4))) & mask;
            if (op < 4 && sz < 4 && v[8*sz-1]) v = v | (~mask & 64'hFFFF_FFFF);
            e.rdata = v[31:0];
            if (cw)
                for (int i = 0; i < sz; i++)
                    rm[ca[5:2]][8*((ca % 4) + i) +: 8] = cd[8*i +: 8];
        end else if (e.gnt) begin
            e.we = lw; e.addr = la & ~32'd3; e.wdata = ld; e.be = 4'hF;
        end
        pend_rv = e.gnt && !lw;
        if (pend_rv) pend_d = rm[la[5:2]];
        if (e.gnt && lw) rm[la[5:2]] = ld;
        wait_c = (lr && !e.gnt) ? wait_c + 1 : 0;
        n_cpu += int'(e.go);
        n_stall += int'(e.stall);
        m_gnt = e.gnt;
        q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 3'b011, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && q.size() > 0) begin
            me = q.pop_front();
            chk("ade", 32'(cpu_ade_o), 32'(me.ade));
            chk("stall", 32'(cpu_stall_o), 32'(me.stall));
            chk("ld_gnt", 32'(ld_gnt_o), 32'(me.gnt));
            chk("dm_we", 32'(dm_we_o), 32'(me.we));
            chk("dm_be", 32'(dm_be_o), 32'(me.be));
            chk("dm_addr", dm_addr_o, me.addr);
            if (me.we) chk("dm_wdata", dm_wdata_o, me.wdata);
            if (me.go) chk("dm_sign", 32'(dm_sign_o), 32'(me.sign));
            if (me.go && !me.we) chk("cpu_rdata", cpu_rdata_o, me.rdata);
            chk("ld_rvalid", 32'(ld_rvalid_o), 32'(me.rv));
            if (me.rv) chk("ld_rdata", ld_rdata_o, me.ldr);
        end
    end

    initial begin
        logic lr, lw;
        logic [31:0] la, ldw;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dm_be", 32'(dm_be_o), 32'd0);
        chk("rst_dm_we", 32'(dm_we_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_rvalid", 32'(ld_rvalid_o), 32'd0);
        chk("rst_rdata", ld_rdata_o, 32'd0);
        chk("rst_perf_cpu", perf_cpu_o, 32'd0);
        chk("rst_perf_stall", perf_stall_o, 32'd0);

        // Starvation: CPU word loads every cycle, LD read held until granted.
        for (int c = 1; c <= 10; c++)
            step(1, 0, 3'b010, 32'h8, 0, (c <= LIMIT + 1), 0, 32'h10, 0);
        idle();
        chk("sc4_perf_cpu", perf_cpu_o, PERF ? 32'd9 : 32'd0);
        chk("sc4_perf_stall", perf_stall_o, PERF ? 32'd1 : 32'd0);

        // Halfword store/load sign handling, misaligned word, LD read-back.
        step(1, 1, 3'b001, 32'h6, 32'h0000BEEF, 0, 0, 0, 0);
        step(1, 0, 3'b001, 32'h6, 0, 0, 0, 0, 0);
        step(1, 0, 3'b101, 32'h6, 0, 0, 0, 0, 0);
        step(1, 0, 3'b010, 32'h5, 0, 1, 0, 32'h8, 0);
        step(0, 0, 3'b011, 0, 0, 1, 1, 32'h10, 32'h12345678);
        step(0, 0, 3'b011, 0, 0, 1, 0, 32'h10, 0);
        idle();
        step(1, 1, 3'b000, 32'h13, 32'h000000C3, 0, 0, 0, 0);
        step(1, 0, 3'b000, 32'h13, 0, 0, 0, 0, 0);
        step(1, 0, 3'b100, 32'h13, 0, 0, 0, 0, 0);

        // Randomised traffic; the LD side holds a request until the model grants it.
        lr = 0; lw = 0; la = 0; ldw = 0;
        for (int c = 0; c < 600; c++) begin
            if (!lr && ($urandom_range(0, 3) == 0)) begin
                lr = 1; lw = 1'($urandom_range(0, 1));
                la = $urandom_range(0, 63); ldw = $urandom;
            end
            step(($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 63), $urandom,
                 lr, lw, la, ldw);
            if (m_gnt) lr = 0;
        end
        if (lr) step(0, 0, 3'b011, 0, 0, lr, lw, la, ldw);
        idle();
        idle();
        chk("perf_cpu", perf_cpu_o, PERF ? 32'(n_cpu) : 32'd0);
        chk("perf_stall", perf_stall_o, PERF ? 32'(n_stall) : 32'd0);
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        // LD write to an unaligned address, then reset during the rvalid cycle.
        @(posedge clk);
        #1;
        ld_req_i = 1; ld_we_i = 1; ld_addr_i = 32'h23; ld_wdata_i = 32'hA5A5A5A5;
        #1;
        chk("ldw_gnt", 32'(ld_gnt_o), 32'd1);
        chk("ldw_addr", dm_addr_o, 32'h20);
        chk("ldw_be", 32'(dm_be_o), 32'hF);
        chk("ldw_we", 32'(dm_we_o), 32'd1);
        @(posedge clk);
        #1;
        ld_we_i = 0;
        @(posedge clk);
        #1;
        ld_req_i = 0;
        chk("ldr_rvalid", 32'(ld_rvalid_o), 32'd1);
        chk("ldr_rdata", ld_rdata_o, 32'hA5A5A5A5);
        rst = 1'b1;
        #1;
        chk("rst_mid_rvalid", 32'(ld_rvalid_o), 32'd0);
        chk("rst_mid_rdata", ld_rdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
